// File: rtl/mem_router_pkg.sv
// rtl/mem_router_pkg.sv - shared types and constants for the memory address router
package mem_router_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RESP,
    HOLD
  } state_t;

  localparam logic [31:0] PHYS_MASK     = 32'h1FFF_FFFF;
  localparam logic [31:0] MEM_CTRL_ADDR = 32'hFFFE_0130;

endpackage

// File: rtl/mem_region_decode.sv
// rtl/mem_region_decode.sv - combinational address-to-target region decode
module mem_region_decode
  import mem_router_pkg::*;
#(
  parameter int                          NUM_TGT  = 4,
  parameter logic [0:NUM_TGT-1][31:0]    TGT_BASE = '0,
  parameter logic [0:NUM_TGT-1][31:0]    TGT_MASK = '0,
  parameter int                          CTRL_TGT = 3,
  localparam int                         IDX_W    = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1
) (
  input  logic [31:0]        addr,
  output logic [NUM_TGT-1:0] match,
  output logic               hit,
  output logic [IDX_W-1:0]   idx,
  output logic [31:0]        offset
);

  logic [31:0] phys;

  always_comb begin
    match  = '0;
    hit    = 1'b0;
    idx    = '0;
    offset = '0;
    phys   = addr & PHYS_MASK;
    if (addr == MEM_CTRL_ADDR) begin
      match[CTRL_TGT] = 1'b1;
      hit             = 1'b1;
      idx             = IDX_W'(CTRL_TGT);
      offset          = phys & ~TGT_MASK[CTRL_TGT];
    end else begin
      // Scan downward so the lowest matching index is the one left standing.
      for (int i = NUM_TGT - 1; i >= 0; i--) begin
        if ((phys & TGT_MASK[i]) == TGT_BASE[i]) begin
          match    = '0;
          match[i] = 1'b1;
          hit      = 1'b1;
          idx      = IDX_W'(i);
          offset   = phys & ~TGT_MASK[i];
        end
      end
    end
  end

endmodule

// File: rtl/mem_addr_router.sv
// rtl/mem_addr_router.sv - routes one upstream access to a decoded target with timeout/retry
module mem_addr_router
  import mem_router_pkg::*;
#(
  parameter int                       NUM_TGT     = 4,
  parameter int                       DATA_W      = 32,
  parameter logic [0:NUM_TGT-1][31:0] TGT_BASE    = {32'h1FC0_0000, 32'h0000_0000, 32'h1F80_0000, 32'h1F80_1000},
  parameter logic [0:NUM_TGT-1][31:0] TGT_MASK    = {32'h1FF8_0000, 32'h1FE0_0000, 32'h1FFF_FC00, 32'h1FFF_E000},
  parameter int                       CTRL_TGT    = 3,
  parameter int                       TIMEOUT_CYC = 100,
  parameter int                       MAX_RETRY   = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [31:0]               addr,
  input  logic [DATA_W-1:0]         wdata,
  input  logic                      ren,
  input  logic                      wen,
  output logic                      ack,
  output logic                      err,
  output logic [DATA_W-1:0]         rdata,
  output logic [NUM_TGT-1:0]        tgt_req,
  output logic                      tgt_we,
  output logic [31:0]               tgt_addr,
  output logic [DATA_W-1:0]         tgt_wdata,
  input  logic [NUM_TGT-1:0]        tgt_ack,
  input  logic [NUM_TGT*DATA_W-1:0] tgt_rdata
);

  localparam int IDX_W = (NUM_TGT > 1) ? $clog2(NUM_TGT) : 1;
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
  localparam int RTY_W = $clog2(MAX_RETRY + 2);

  state_t              state, state_nx;
  logic [CNT_W-1:0]    cnt, cnt_nx;
  logic [RTY_W-1:0]    retry, retry_nx;
  logic                gap, gap_nx;
  logic                ack_r, ack_nx, err_r, err_nx, we_r, we_nx;
  logic [DATA_W-1:0]   rdata_r, rdata_nx, wdata_r, wdata_nx;
  logic [31:0]         off_r, off_nx;
  logic [IDX_W-1:0]    sel_r, sel_nx;

  logic [NUM_TGT-1:0]  dec_match;
  logic                dec_hit;
  logic [IDX_W-1:0]    dec_idx;
  logic [31:0]         dec_offset;
  logic [DATA_W-1:0]   sel_rdata;

  mem_region_decode #(
    .NUM_TGT  (NUM_TGT),
    .TGT_BASE (TGT_BASE),
    .TGT_MASK (TGT_MASK),
    .CTRL_TGT (CTRL_TGT)
  ) u_decode (
    .addr   (addr),
    .match  (dec_match),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .offset (dec_offset)
  );

  assign sel_rdata = tgt_rdata[int'(sel_r)*DATA_W +: DATA_W];
  assign ack       = ack_r;
  assign err       = err_r;
  assign rdata     = rdata_r;
  assign tgt_we    = we_r;
  assign tgt_addr  = off_r;
  assign tgt_wdata = wdata_r;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    retry_nx = retry;
    gap_nx   = gap;
    ack_nx   = ack_r;
    err_nx   = err_r;
    rdata_nx = rdata_r;
    we_nx    = we_r;
    off_nx   = off_r;
    wdata_nx = wdata_r;
    sel_nx   = sel_r;
    tgt_req  = '0;
    case (state)
      IDLE: begin
        if (ren || wen) begin
          we_nx    = ~ren;
          off_nx   = dec_offset;
          wdata_nx = wdata;
          sel_nx   = dec_idx;
          rdata_nx = '0;
          retry_nx = '0;
          cnt_nx   = '0;
          gap_nx   = 1'b0;
          err_nx   = ~dec_hit;
          state_nx = dec_hit ? ISSUE : RESP;
        end
      end
      ISSUE: begin
        cnt_nx = '0;
        // After a timeout the first ISSUE cycle is a request-free gap.
        if (gap) begin
          gap_nx = 1'b0;
        end else begin
          tgt_req[sel_r] = 1'b1;
          state_nx       = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        tgt_req[sel_r] = 1'b1;
        if (tgt_ack[sel_r]) begin
          state_nx = RESP;
          if (!we_r) rdata_nx = sel_rdata;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          if (retry == RTY_W'(MAX_RETRY)) begin
            state_nx = RESP;
            err_nx   = 1'b1;
            rdata_nx = '0;
          end else begin
            retry_nx = retry + 1'b1;
            gap_nx   = 1'b1;
            state_nx = ISSUE;
          end
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      RESP: begin
        ack_nx   = 1'b1;
        state_nx = HOLD;
      end
      HOLD: begin
        if (!ren && !wen) begin
          ack_nx   = 1'b0;
          err_nx   = 1'b0;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      retry   <= '0;
      gap     <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= '0;
      we_r    <= 1'b0;
      off_r   <= '0;
      wdata_r <= '0;
      sel_r   <= '0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      retry   <= retry_nx;
      gap     <= gap_nx;
      ack_r   <= ack_nx;
      err_r   <= err_nx;
      rdata_r <= rdata_nx;
      we_r    <= we_nx;
      off_r   <= off_nx;
      wdata_r <= wdata_nx;
      sel_r   <= sel_nx;
    end
  end

endmodule

// File: tb/tb_mem_addr_router.sv
// tb/tb_mem_addr_router.sv - directed self-checking bench for mem_addr_router
module tb_mem_addr_router;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  addr, wdata, rdata, tgt_addr, tgt_wdata;
  logic         ren, wen, ack, err, tgt_we;
  logic [3:0]   tgt_req, tgt_ack;
  logic [127:0] tgt_rdata;
  int           checks = 0;
  int           passes = 0;

  always #5 clk = ~clk;

  mem_addr_router dut (
    .clk       (clk),
    .rst       (rst),
    .addr      (addr),
    .wdata     (wdata),
    .ren       (ren),
    .wen       (wen),
    .ack       (ack),
    .err       (err),
    .rdata     (rdata),
    .tgt_req   (tgt_req),
    .tgt_we    (tgt_we),
    .tgt_addr  (tgt_addr),
    .tgt_wdata (tgt_wdata),
    .tgt_ack   (tgt_ack),
    .tgt_rdata (tgt_rdata)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Read whose target acks in its first WAIT_ACK cycle; lat = cycles from ren to ack, -1 if none.
  task automatic do_read(input logic [31:0] a, input int t, input logic [31:0] d,
                         output int lat, output logic [3:0] seen);
    ren = 1'b1; addr = a; lat = -1; seen = '0;
    tick; seen |= tgt_req;
    tick; seen |= tgt_req;
    tgt_ack[t] = 1'b1; tgt_rdata[t*32 +: 32] = d;
    for (int c = 3; c <= 12; c++) begin
      tick; tgt_ack = '0; seen |= tgt_req;
      if (ack === 1'b1) begin lat = c; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ren = 1'b0; wen = 1'b0; addr = '0; wdata = '0; tgt_ack = '0; tgt_rdata = '0;
    tick; tick;
    checks++; if (ack !== 1'b0) $display("FAIL reset_ack: got %b exp 0", ack); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL reset_err: got %b exp 0", err); else passes++;
    checks++; if (rdata !== 32'h0) $display("FAIL reset_rdata: got %h exp 0", rdata); else passes++;
    checks++; if (tgt_req !== 4'h0) $display("FAIL reset_tgt_req: got %b exp 0000", tgt_req); else passes++;
    checks++; if (tgt_we !== 1'b0) $display("FAIL reset_tgt_we: got %b exp 0", tgt_we); else passes++;
    rst = 1'b0;
    tick;
    checks++; if (tgt_req !== 4'h0) $display("FAIL idle_tgt_req: got %b exp 0000", tgt_req); else passes++;
  endtask

  task automatic test_read_basic;
    int lat; logic [3:0] seen;
    do_read(32'hBFC0_0010, 0, 32'hDEAD_BEEF, lat, seen);
    checks++; if (lat != 4) $display("FAIL read_latency: got %0d exp 4", lat); else passes++;
    checks++; if (rdata !== 32'hDEAD_BEEF) $display("FAIL read_rdata: got %h exp deadbeef", rdata); else passes++;
    checks++; if (err !== 1'b0) $display("FAIL read_err: got %b exp 0", err); else passes++;
    checks++; if (tgt_addr !== 32'h10) $display("FAIL read_tgt_addr: got %h exp 00000010", tgt_addr); else passes++;
    checks++; if (seen !== 4'b0001) $display("FAIL read_tgt_sel: got %b exp 0001", seen); else passes++;
    checks++; if (tgt_req !== 4'h0) $display("FAIL read_req_drop: got %b exp 0000", tgt_req); else passes++;
    tick; tick;
    checks++; if (ack !== 1'b1) $display("FAIL read_ack_hold: got %b exp 1", ack); else passes++;
    ren = 1'b0;
    tick;
    checks++; if (ack !== 1'b0) $display("FAIL read_ack_clear: got %b exp 0", ack); else passes++;
  endtask

  task automatic test_write;
    wen = 1'b1; addr = 32'h8000_1000; wdata = 32'h1234_5678;
    tick;
    checks++; if (tgt_req !== 4'b0010) $display("FAIL wr_tgt_req: got %b exp 0010", tgt_req); else passes++;
    checks++; if (tgt_we !== 1'b1) $display("FAIL wr_tgt_we: got %b exp 1", tgt_we); else passes++;
    checks++; if (tgt_addr !== 32'h1000) $display("FAIL wr_tgt_addr: got %h exp 00001000", tgt_addr); else passes++;
    checks++; if (tgt_wdata !== 32'h1234_5678) $display("FAIL wr_tgt_wdata: got %h exp 12345678", tgt_wdata); else passes++;
    addr = 32'h0; wdata = 32'hFFFF_FFFF;
    tick;
    checks++; if ({tgt_addr, tgt_wdata} !== {32'h1000, 32'h1234_5678})
      $display("FAIL wr_capture: got %h/%h exp 00001000/12345678", tgt_addr, tgt_wdata); else passes++;
    tgt_ack = 4'b0010;
    tick; tgt_ack = '0;
    tick;
    checks++; if ({ack, err} !== 2'b10) $display("FAIL wr_ack: got ack/err %b exp 10", {ack, err}); else passes++;
    repeat (3) tick;
    checks++; if (ack !== 1'b1) $display("FAIL wr_ack_hold: got %b exp 1", ack); else passes++;
    wen = 1'b0;
    tick;
    checks++; if (ack !== 1'b0) $display("FAIL wr_ack_clear: got %b exp 0", ack); else passes++;
  endtask

  task automatic test_ctrl_unmapped;
    int lat; logic [3:0] seen;
    ren = 1'b1; addr = 32'hFFFE_0130;
    tick;
    checks++; if (tgt_req !== 4'b1000) $display("FAIL ctrl_tgt_req: got %b exp 1000", tgt_req); else passes++;
    checks++; if (tgt_addr !== 32'h130) $display("FAIL ctrl_tgt_addr: got %h exp 00000130", tgt_addr); else passes++;
    tick;
    tgt_ack = 4'b0111;
    tgt_rdata = {32'hCAFE_0130, 32'h2222_2222, 32'h1111_1111, 32'h0000_0BAD};
    tick; tgt_ack = '0;
    checks++; if ({tgt_req, ack} !== 5'b10000) $display("FAIL foreign_ack_ignored: got req/ack %b exp 10000", {tgt_req, ack}); else passes++;
    tgt_ack = 4'b1000;
    tick; tgt_ack = '0;
    tick;
    checks++; if ({ack, rdata} !== {1'b1, 32'hCAFE_0130}) $display("FAIL ctrl_rdata: got ack %b rdata %h exp 1 cafe0130", ack, rdata); else passes++;
    ren = 1'b0;
    tick;
    ren = 1'b1; addr = 32'h1F40_0000; seen = '0; lat = -1;
    for (int c = 1; c <= 6; c++) begin
      tick; seen |= tgt_req;
      if (ack === 1'b1) begin lat = c; break; end
    end
    checks++; if (lat != 2) $display("FAIL unmapped_latency: got %0d exp 2", lat); else passes++;
    checks++; if (seen !== 4'h0) $display("FAIL unmapped_tgt_req: got %b exp 0000", seen); else passes++;
    checks++; if ({err, rdata} !== {1'b1, 32'h0}) $display("FAIL unmapped_resp: got err %b rdata %h exp 1 0", err, rdata); else passes++;
    ren = 1'b0;
    tick;
    checks++; if ({ack, err} !== 2'b00) $display("FAIL unmapped_clear: got ack/err %b exp 00", {ack, err}); else passes++;
  endtask

  task automatic test_timeout;
    int run, low, ack_c; int runs[$]; int gaps[$]; bit len_ok;
    run = 0; low = 0; ack_c = -1; len_ok = 1'b1;
    ren = 1'b1; addr = 32'hBF80_0004;
    for (int c = 1; c <= 600; c++) begin
      tick;
      if (tgt_req[2]) begin
        if (low > 0 && runs.size() > 0) gaps.push_back(low);
        low = 0; run++;
      end else begin
        if (run > 0) begin runs.push_back(run); run = 0; end
        low++;
      end
      if (c == 1) begin
        checks++; if (tgt_addr !== 32'h4) $display("FAIL to_tgt_addr: got %h exp 00000004", tgt_addr); else passes++;
      end
      if (ack === 1'b1) begin ack_c = c; break; end
    end
    foreach (runs[i]) if (runs[i] != 101) len_ok = 1'b0;
    foreach (gaps[i]) if (gaps[i] != 1) len_ok = 1'b0;
    checks++; if (ack_c < 0) $display("FAIL to_no_ack: got no ack in 600 cycles exp ack at 307"); else passes++;
    checks++; if (runs.size() != 3 || gaps.size() != 2)
      $display("FAIL to_attempts: got %0d req runs %0d gaps exp 3 runs 2 gaps", runs.size(), gaps.size()); else passes++;
    checks++; if (!len_ok) $display("FAIL to_run_lengths: got a run != 101 or gap != 1 exp 101/1"); else passes++;
    checks++; if (ack_c != 307) $display("FAIL to_ack_cycle: got %0d exp 307", ack_c); else passes++;
    checks++; if ({err, rdata} !== {1'b1, 32'h0}) $display("FAIL to_resp: got err %b rdata %h exp 1 0", err, rdata); else passes++;
    ren = 1'b0;
    tick;
  endtask

  task automatic test_ack_at_timeout;
    ren = 1'b1; wen = 1'b1; addr = 32'hBF80_0008; wdata = 32'hAAAA_5555;
    tick;
    checks++; if ({tgt_req, tgt_we} !== 5'b01000) $display("FAIL both_read_wins: got req/we %b exp 01000", {tgt_req, tgt_we}); else passes++;
    tick;
    repeat (99) tick;
    checks++; if (tgt_req !== 4'b0100) $display("FAIL to_edge_req: got %b exp 0100", tgt_req); else passes++;
    tgt_ack[2] = 1'b1; tgt_rdata[64 +: 32] = 32'h5A5A_0100;
    tick; tgt_ack = '0;
    tick;
    checks++; if ({ack, err, rdata} !== {2'b10, 32'h5A5A_0100})
      $display("FAIL ack_beats_timeout: got ack %b err %b rdata %h exp 1 0 5a5a0100", ack, err, rdata); else passes++;
    ren = 1'b0; wen = 1'b0;
    tick;
  endtask

  task automatic test_reset_mid;
    int lat; logic [3:0] seen;
    ren = 1'b1; addr = 32'hBFC0_0020;
    tick; tick;
    checks++; if (tgt_req !== 4'b0001) $display("FAIL mid_pre_req: got %b exp 0001", tgt_req); else passes++;
    #1 rst = 1'b1;
    #1;
    checks++; if ({tgt_req, ack} !== 5'b00000) $display("FAIL mid_rst_async: got req/ack %b exp 00000", {tgt_req, ack}); else passes++;
    ren = 1'b0;
    tick; tick;
    rst = 1'b0;
    tgt_ack = 4'b0001;
    tick; tgt_ack = '0;
    tick;
    checks++; if ({tgt_req, ack} !== 5'b00000) $display("FAIL late_ack_ignored: got req/ack %b exp 00000", {tgt_req, ack}); else passes++;
    do_read(32'hBFC0_0040, 0, 32'h600D_F00D, lat, seen);
    checks++; if (lat != 4 || seen !== 4'b0001)
      $display("FAIL post_rst_read: got lat %0d sel %b exp 4 0001", lat, seen); else passes++;
    checks++; if ({err, rdata} !== {1'b0, 32'h600D_F00D}) $display("FAIL post_rst_rdata: got err %b rdata %h exp 0 600df00d", err, rdata); else passes++;
    ren = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running exp finished");
    $fatal(1);
  end

  initial begin
    test_reset;
    test_read_basic;
    test_write;
    test_ctrl_unmapped;
    test_timeout;
    test_ack_at_timeout;
    test_reset_mid;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
